// File: rtl/avalon_pio_debounce.sv
// Avalon-MM pushbutton/LED PIO: debounced inputs, sticky edge capture,
// maskable level interrupt and a writable output register.
module avalon_pio_debounce #(
    parameter int          IN_WIDTH        = 4,
    parameter int          OUT_WIDTH       = 32,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          EDGE_MODE       = 2,
    parameter int          IN_ACTIVE_LOW   = 1,
    parameter logic [31:0] OUT_RESET       = 32'h0
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic [1:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 irq,
    input  logic [IN_WIDTH-1:0]  pushbutton_export,
    output logic [OUT_WIDTH-1:0] to_hex_to_led_export
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [IN_WIDTH-1:0] IDLE_RAW =
        (IN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [IN_WIDTH-1:0]  r_sync1;
    logic [IN_WIDTH-1:0]  r_sync2;
    logic [IN_WIDTH-1:0]  r_stable;
    logic [IN_WIDTH-1:0]  r_mask;
    logic [IN_WIDTH-1:0]  r_edge;
    logic [CW-1:0]        r_cnt [IN_WIDTH];
    logic [OUT_WIDTH-1:0] r_out;
    logic [31:0]          r_rdata;
    logic                 r_irq;

    logic [IN_WIDTH-1:0]  w_logical;
    logic [IN_WIDTH-1:0]  w_stable_nxt;
    logic [IN_WIDTH-1:0]  w_rise;
    logic [IN_WIDTH-1:0]  w_fall;
    logic [IN_WIDTH-1:0]  w_set;
    logic [IN_WIDTH-1:0]  w_w1c;
    logic [31:0]          w_rd_mux;

    assign w_logical = r_sync2 ^ IDLE_RAW;

    // A channel flips only after DEBOUNCE_CYCLES consecutive mismatches
    always_comb begin
        w_stable_nxt = r_stable;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (w_logical[i] != r_stable[i] && r_cnt[i] == CNT_LAST)
                w_stable_nxt[i] = w_logical[i];
        end
    end

    assign w_rise = w_stable_nxt & ~r_stable;
    assign w_fall = ~w_stable_nxt & r_stable;
    assign w_set  = (EDGE_MODE == 0) ? w_fall :
                    (EDGE_MODE == 1) ? w_rise :
                    (w_rise | w_fall);

    assign w_w1c = (avs_write && avs_address == 2'd2) ?
                   avs_writedata[IN_WIDTH-1:0] : '0;

    always_comb begin
        w_rd_mux = '0;
        case (avs_address)
            2'd0:    w_rd_mux[IN_WIDTH-1:0]  = r_stable;
            2'd1:    w_rd_mux[IN_WIDTH-1:0]  = r_mask;
            2'd2:    w_rd_mux[IN_WIDTH-1:0]  = r_edge;
            default: w_rd_mux[OUT_WIDTH-1:0] = r_out;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1  <= IDLE_RAW;
            r_sync2  <= IDLE_RAW;
            r_stable <= '0;
            r_mask   <= '0;
            r_edge   <= '0;
            r_out    <= OUT_RESET[OUT_WIDTH-1:0];
            r_rdata  <= '0;
            r_irq    <= 1'b0;
            for (int i = 0; i < IN_WIDTH; i++)
                r_cnt[i] <= '0;
        end else begin
            r_sync1  <= pushbutton_export;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_nxt;
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (w_logical[i] == r_stable[i] || r_cnt[i] == CNT_LAST)
                    r_cnt[i] <= '0;
                else
                    r_cnt[i] <= r_cnt[i] + CW'(1);
            end
            // New edges win over a same-cycle clear
            r_edge <= (r_edge & ~w_w1c) | w_set;
            r_irq  <= |(r_edge & r_mask);
            if (avs_read)
                r_rdata <= w_rd_mux;
            if (avs_write && avs_address == 2'd1)
                r_mask <= avs_writedata[IN_WIDTH-1:0];
            if (avs_write && avs_address == 2'd3)
                r_out <= avs_writedata[OUT_WIDTH-1:0];
        end
    end

    assign avs_readdata         = r_rdata;
    assign irq                  = r_irq;
    assign to_hex_to_led_export = r_out;

endmodule
